data_memory_sb: RTL
===================

Name: data_memory_sb

Overview:
- Parametrised word-addressed data memory for the superscalar core, placed between the ROB commit stage and the load unit.
- Committed stores go into an in-order store buffer with byte enables. The buffer drains one entry per cycle into a synchronous-write RAM.
- Loads have one-cycle registered latency. Each load byte comes from the youngest matching buffered store, or from RAM if no store matches, so no store is ever lost or reordered.

Parameters:
- DATA_W, 32, data word width in bits (multiple of 8)
- ADDR_W, 32, byte-address width
- DEPTH, 256, RAM words (power of 2)
- SB_DEPTH, 4, store-buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  committed store request
- st_ready  out  1  store buffer can accept this cycle
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data, lane-aligned
- st_be  in  DATA_W/8  byte enables
- ld_valid  in  1  load request
- ld_addr  in  ADDR_W  load byte address
- ld_data  out  DATA_W  load result, valid the cycle after ld_valid
- ld_data_valid  out  1  ld_data is valid
- ld_fwd  out  1  at least one byte of ld_data was forwarded from the buffer
- drain_hold  in  1  stall draining this cycle (memory-side backpressure)
- sb_empty  out  1  store buffer holds no entries
- sb_count  out  clog2(SB_DEPTH)+1  entries held

Behaviour:
- Word index = addr[clog2(DEPTH)+1:2]. Bits [1:0] are ignored. Upper bits are truncated, so addresses wrap modulo DEPTH words.
- Reset (asynchronous, active-high) clears head, tail, count and all entry valid bits. ld_data_valid=0, ld_fwd=0, ld_data=0, sb_empty=1, sb_count=0, st_ready=1. RAM contents are not reset.
- st_ready = (count != SB_DEPTH). It is not a function of the same-cycle drain: a full buffer refuses a store even in a cycle where it drains.
- Enqueue: on st_valid && st_ready, {word index, data, be} is written at tail and tail increments (wrap modulo SB_DEPTH).
- Drain: if count>0 && !drain_hold, the head entry writes RAM bytes where be=1 at the clock edge, and head increments.
- Enqueue and drain in the same cycle leave count unchanged.
- An entry with be=0 still occupies a slot and drains as a no-op write.
- Load: on ld_valid, each byte lane is resolved over the entries valid at the start of the cycle, including the head being drained that cycle.
  - The lane takes the youngest entry with a matching index and be[lane]=1.
  - Otherwise the lane takes the RAM read of the pre-edge contents.
  - The merged word is registered. ld_data_valid=1 and ld_fwd are asserted in cycle N+1.
- A store enqueued in the same cycle as a load is NOT visible to that load.
- When ld_valid=0, ld_data_valid=0 next cycle and ld_data holds its previous value.
- An ld_valid asserted while rst is high is discarded.
- Reset mid-operation discards all undrained stores. This is intended: the memory is flushed along with the pipeline.
- Implementation is a 2-state drain FSM:
  - IDLE: count==0.
  - DRAIN: count>0. Moves to IDLE when the last entry drains and no enqueue occurs.
  - drain_hold only stalls inside DRAIN.

Decomposition:
- Shared package dm_pkg:
  - sb_entry_t struct {idx, data, be}
  - function clog2
  - constant BYTES = DATA_W/8
- One sub-module: sb_fwd_merge. It is combinational and does per-lane youngest-match selection over the entry array and the RAM word.
- The RAM array and the FIFO pointers stay in the top module.

Test Plan:
- Reset, then store 0x11223344 to 0x10 (be=F), drain_hold=0; load 0x10 two cycles later → ld_data=0x11223344, ld_fwd=0, ld_data_valid exactly 1 cycle after ld_valid.
- drain_hold=1. Store 0xAABBCCDD to 0x20 (be=F), then 0x000000EE to 0x20 (be=1). Load 0x20 → 0xAABBCCEE, ld_fwd=1, sb_count=2.
- drain_hold=1. Enqueue SB_DEPTH=4 stores → st_ready=0 after the 4th. A 5th st_valid is refused and sb_count stays 4. Release hold → one entry drains per cycle, sb_empty=1 after 4 cycles, RAM holds all 4 values.
- Same-cycle store 0x5 to 0x30 and load 0x30 (RAM holds 0x0) → ld_data=0x0. Load 0x30 again next cycle → 0x5 forwarded.
- Address 0x400 with DEPTH=256 → aliases to word 0; store/load there matches a load of address 0x0.
- Assert rst asynchronously mid-edge with 3 entries buffered → sb_count=0 and st_ready=1 immediately. Those stores never reach RAM. Loads of their addresses return the old RAM data.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the store-buffered data memory.
package dm_pkg;

    localparam int unsigned DM_DATA_W   = 32;
    localparam int unsigned DM_ADDR_W   = 32;
    localparam int unsigned DM_DEPTH    = 256;
    localparam int unsigned DM_SB_DEPTH = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    localparam int unsigned BYTES = DM_DATA_W / 8;
    localparam int unsigned IDX_W = clog2(DM_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0]     idx;
        logic [DM_DATA_W-1:0] data;
        logic [BYTES-1:0]     be;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane load resolution: youngest buffered store with a matching word and
// enabled byte wins, otherwise the RAM byte passes through.
module sb_fwd_merge
    import dm_pkg::*;
#(
    parameter int unsigned SB_DEPTH = DM_SB_DEPTH,
    parameter int unsigned PTR_W    = clog2(SB_DEPTH)
) (
    input  sb_entry_t [SB_DEPTH-1:0] entries,
    input  logic [SB_DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]         head,
    input  logic [IDX_W-1:0]         ld_idx,
    input  logic [DM_DATA_W-1:0]     ram_word,
    output logic [DM_DATA_W-1:0]     merged,
    output logic                     fwd
);

    always_comb begin
        logic [PTR_W-1:0] slot;
        merged = ram_word;
        fwd    = 1'b0;
        slot   = '0;
        // Walk oldest to youngest so later matches overwrite earlier ones.
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            slot = head + PTR_W'(k);
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (valid[slot] && (entries[slot].idx == ld_idx) && entries[slot].be[b]) begin
                    merged[b*8 +: 8] = entries[slot].data[b*8 +: 8];
                    fwd              = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_sb.sv
// Word-addressed data memory fronted by an in-order store buffer that drains
// one entry per cycle; loads merge buffered bytes over the RAM read.
module data_memory_sb
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W   = DM_DATA_W,
    parameter int unsigned ADDR_W   = DM_ADDR_W,
    parameter int unsigned DEPTH    = DM_DEPTH,
    parameter int unsigned SB_DEPTH = DM_SB_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        st_valid,
    output logic                        st_ready,
    input  logic [ADDR_W-1:0]           st_addr,
    input  logic [DATA_W-1:0]           st_data,
    input  logic [DATA_W/8-1:0]         st_be,
    input  logic                        ld_valid,
    input  logic [ADDR_W-1:0]           ld_addr,
    output logic [DATA_W-1:0]           ld_data,
    output logic                        ld_data_valid,
    output logic                        ld_fwd,
    input  logic                        drain_hold,
    output logic                        sb_empty,
    output logic [clog2(SB_DEPTH):0]    sb_count
);

    localparam int unsigned PTR_W = clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, DRAIN} drain_state_t;

    drain_state_t              state_q, state_d;
    logic [PTR_W-1:0]          head, tail;
    logic [CNT_W-1:0]          count;
    logic [SB_DEPTH-1:0]       valid;
    sb_entry_t [SB_DEPTH-1:0]  entries;
    logic [DATA_W-1:0]         ram [DEPTH];

    logic                      enq, do_drain, fwd;
    logic [IDX_W-1:0]          st_idx, ld_idx;
    logic [DATA_W-1:0]         merged;
    sb_entry_t                 head_entry;
    logic                      unused_addr_bits;

    assign st_idx     = st_addr[IDX_W+1:2];
    assign ld_idx     = ld_addr[IDX_W+1:2];
    assign head_entry = entries[head];
    assign enq        = st_valid && st_ready;
    assign unused_addr_bits = ^{st_addr[ADDR_W-1:IDX_W+2], st_addr[1:0],
                                ld_addr[ADDR_W-1:IDX_W+2], ld_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enq) state_d = DRAIN;
            DRAIN:   if (do_drain && !enq && (count == CNT_W'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_drain = (state_q == DRAIN) && !drain_hold;
        st_ready = (count != CNT_W'(SB_DEPTH));
        sb_empty = (count == '0);
        sb_count = count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (enq) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (do_drain) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            count <= count + CNT_W'(enq) - CNT_W'(do_drain);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) entries[tail] <= '{idx: st_idx, data: st_data, be: st_be};
    end

    always_ff @(posedge clk) begin
        if (do_drain) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (head_entry.be[b]) ram[head_entry.idx][b*8 +: 8] <= head_entry.data[b*8 +: 8];
            end
        end
    end

    sb_fwd_merge #(
        .SB_DEPTH (SB_DEPTH),
        .PTR_W    (PTR_W)
    ) u_merge (
        .entries  (entries),
        .valid    (valid),
        .head     (head),
        .ld_idx   (ld_idx),
        .ram_word (ram[ld_idx]),
        .merged   (merged),
        .fwd      (fwd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_data       <= '0;
            ld_data_valid <= 1'b0;
            ld_fwd        <= 1'b0;
        end else begin
            ld_data_valid <= ld_valid;
            ld_fwd        <= ld_valid && fwd;
            if (ld_valid) ld_data <= merged;
        end
    end

endmodule
